// File: rtl/dsi_stream_packer.sv
// Byte-stream repacker: variable-size input beats in, q_size_i-byte words out, with flush of a partial tail word.
// A completed word is registered the cycle after its last byte arrives; d_ready_o drops when a full beat no longer fits or a flush is draining.
module dsi_stream_packer #(
  parameter int G_IN_BYTES  = 4,
  parameter int G_OUT_BYTES = 4,
  parameter int G_BUF_BYTES = 16,
  parameter bit G_MSB_FIRST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [8*G_IN_BYTES-1:0]  d_i,
  input  logic [3:0]               d_size_i,
  input  logic                     d_valid_i,
  output logic                     d_ready_o,
  input  logic [3:0]               q_size_i,
  output logic [8*G_OUT_BYTES-1:0] q_o,
  output logic [G_OUT_BYTES-1:0]   q_be_o,
  output logic                     q_valid_o,
  input  logic                     q_ready_i,
  input  logic                     flush_i,
  output logic                     empty_o,
  output logic [4:0]               level_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STREAM, ST_FLUSH} state_t;

  if (G_BUF_BYTES < G_IN_BYTES + G_OUT_BYTES || G_BUF_BYTES > 31) begin : g_param_check
    $error("dsi_stream_packer: G_BUF_BYTES must be >= G_IN_BYTES + G_OUT_BYTES and <= 31");
  end

  logic [7:0]               r_buf [G_BUF_BYTES];
  logic [4:0]               r_count;
  state_t                   r_state;
  logic [8*G_OUT_BYTES-1:0] r_q;
  logic [G_OUT_BYTES-1:0]   r_be;
  logic                     r_q_vld;

  logic                     w_acc;
  logic                     w_out_free;
  logic                     w_flush;
  logic                     w_flush_n;
  int                       w_cnt;
  int                       w_in_n;
  int                       w_q_n;
  int                       w_avail;
  int                       w_take;
  int                       w_cnt_n;
  logic [7:0]               w_in_byte [G_IN_BYTES];
  logic [7:0]               w_mrg [G_BUF_BYTES];
  logic [7:0]               w_buf_n [G_BUF_BYTES];
  logic [8*G_OUT_BYTES-1:0] w_q_nxt;
  logic [G_OUT_BYTES-1:0]   w_be_nxt;
  state_t                   w_state_n;

  assign d_ready_o = (r_state != ST_FLUSH) && (G_BUF_BYTES - int'(r_count) >= G_IN_BYTES);
  assign q_o       = r_q;
  assign q_be_o    = r_be;
  assign q_valid_o = r_q_vld;
  assign level_o   = r_count;
  assign empty_o   = (r_count == 5'd0) && !r_q_vld;

  always_comb begin
    w_cnt      = int'(r_count);
    w_acc      = d_valid_i && d_ready_o;
    w_in_n     = 0;
    if (w_acc) w_in_n = (int'(d_size_i) > G_IN_BYTES) ? G_IN_BYTES : int'(d_size_i);
    w_q_n      = (q_size_i == 4'd0 || int'(q_size_i) > G_OUT_BYTES) ? G_OUT_BYTES : int'(q_size_i);
    w_out_free = !r_q_vld || q_ready_i;
    w_flush    = flush_i || (r_state == ST_FLUSH);
    w_avail    = w_cnt + w_in_n;

    // Reorder the incoming beat into stream order (stream byte 0 first).
    for (int k = 0; k < G_IN_BYTES; k++) begin
      w_in_byte[k] = 8'h00;
      for (int j = 0; j < G_IN_BYTES; j++) begin
        if (G_MSB_FIRST) begin
          if (j == w_in_n - 1 - k) w_in_byte[k] = d_i[8*j +: 8];
        end else begin
          if (j == k) w_in_byte[k] = d_i[8*j +: 8];
        end
      end
    end

    // Buffered bytes followed by this cycle's beat, so a word can complete without an extra cycle.
    for (int i = 0; i < G_BUF_BYTES; i++) begin
      w_mrg[i] = (i < w_cnt) ? r_buf[i] : 8'h00;
      for (int k = 0; k < G_IN_BYTES; k++) begin
        if (k < w_in_n && i == w_cnt + k) w_mrg[i] = w_in_byte[k];
      end
    end

    if (w_out_free && w_avail >= w_q_n) w_take = w_q_n;
    else if (w_out_free && w_flush && w_avail > 0) w_take = w_avail;
    else w_take = 0;
    w_cnt_n = w_avail - w_take;

    w_q_nxt  = '0;
    w_be_nxt = '0;
    for (int k = 0; k < G_OUT_BYTES; k++) begin
      w_q_nxt[8*k +: 8] = (k < w_take) ? w_mrg[k] : 8'h00;
      w_be_nxt[k]       = (k < w_take);
    end

    for (int i = 0; i < G_BUF_BYTES; i++) begin
      w_buf_n[i] = 8'h00;
      for (int j = i; j < G_BUF_BYTES; j++) begin
        if (j == i + w_take) w_buf_n[i] = w_mrg[j];
      end
    end

    // Flush stays pending until the buffer is drained and the tail word has somewhere to go.
    w_flush_n = w_flush && !(w_cnt_n == 0 && w_out_free);
    if (w_flush_n) w_state_n = ST_FLUSH;
    else if (w_cnt_n == 0) w_state_n = ST_IDLE;
    else if (w_cnt_n < w_q_n) w_state_n = ST_FILL;
    else w_state_n = ST_STREAM;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= 5'd0;
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_be    <= '0;
      r_q_vld <= 1'b0;
      for (int i = 0; i < G_BUF_BYTES; i++) r_buf[i] <= 8'h00;
    end else begin
      r_count <= 5'(w_cnt_n);
      r_state <= w_state_n;
      for (int i = 0; i < G_BUF_BYTES; i++) r_buf[i] <= w_buf_n[i];
      if (w_take != 0) begin
        r_q     <= w_q_nxt;
        r_be    <= w_be_nxt;
        r_q_vld <= 1'b1;
      end else if (q_ready_i) begin
        r_q_vld <= 1'b0;
      end
    end
  end

endmodule
